calc1: RTL and testbench

CALC1 -- requirements
Module: calc1

---
 rtl/calc1_pkg.sv | 21 ++
 rtl/calc1_port.sv | 91 +++++++++
 rtl/calc1.sv | 65 ++++++
 tb/tb_calc1.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared encodings and widths for the calc1 four-port calculator.
package calc1_pkg;

   localparam int unsigned CmdW   = 4;
   localparam int unsigned DataW  = 32;
   localparam int unsigned RespW  = 2;
   localparam int unsigned ShamtW = 5;

   localparam logic [CmdW-1:0] CmdNop = 4'd0;
   localparam logic [CmdW-1:0] CmdAdd = 4'd1;
   localparam logic [CmdW-1:0] CmdSub = 4'd2;
   localparam logic [CmdW-1:0] CmdShl = 4'd5;
   localparam logic [CmdW-1:0] CmdShr = 4'd6;

   localparam logic [RespW-1:0] RespNone = 2'd0;
   localparam logic [RespW-1:0] RespOk   = 2'd1;
   localparam logic [RespW-1:0] RespErr  = 2'd2;

   typedef enum logic {StIdle, StOp2} state_e;

endpackage

// File: rtl/calc1_port.sv
// One calculator port: two-cycle operand capture FSM plus a combinational ALU
// whose result is registered on the operand-2 edge.
module calc1_port
   import calc1_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [CmdW-1:0]  i_cmd,
   input  logic [DataW-1:0] i_data,
   output logic [DataW-1:0] o_data,
   output logic [RespW-1:0] o_resp
);

   state_e             r_state;
   logic [CmdW-1:0]    r_cmd;
   logic [DataW-1:0]   r_op1;
   logic [DataW-1:0]   r_data;
   logic [RespW-1:0]   r_resp;

   logic [DataW:0]     w_sum;
   logic [ShamtW-1:0]  w_shamt;
   logic [DataW-1:0]   w_alu_data;
   logic [RespW-1:0]   w_alu_resp;

   // In OP2 the live data input is operand 2, so the ALU reads it directly.
   always_comb begin
      w_sum      = {1'b0, r_op1} + {1'b0, i_data};
      w_shamt    = i_data[ShamtW-1:0];
      w_alu_data = '0;
      w_alu_resp = RespErr;
      case (r_cmd)
         CmdAdd: begin
            if (!w_sum[DataW]) begin
               w_alu_data = w_sum[DataW-1:0];
               w_alu_resp = RespOk;
            end
         end
         CmdSub: begin
            if (i_data <= r_op1) begin
               w_alu_data = r_op1 - i_data;
               w_alu_resp = RespOk;
            end
         end
         CmdShl: begin
            w_alu_data = r_op1 << w_shamt;
            w_alu_resp = RespOk;
         end
         CmdShr: begin
            w_alu_data = r_op1 >> w_shamt;
            w_alu_resp = RespOk;
         end
         default: begin
            w_alu_data = '0;
            w_alu_resp = RespErr;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cmd   <= CmdNop;
         r_op1   <= '0;
         r_data  <= '0;
         r_resp  <= RespNone;
      end else begin
         // Responses last a single cycle unless overwritten below.
         r_data <= '0;
         r_resp <= RespNone;
         case (r_state)
            StIdle: begin
               if (i_cmd != CmdNop) begin
                  r_cmd   <= i_cmd;
                  r_op1   <= i_data;
                  r_state <= StOp2;
               end
            end
            StOp2: begin
               r_data  <= w_alu_data;
               r_resp  <= w_alu_resp;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_data = r_data;
   assign o_resp = r_resp;

endmodule

// File: rtl/calc1.sv
// calc1 top: four independent calculator ports sharing clock and reset.
module calc1
   import calc1_pkg::*;
(
   output logic [0:31] out_data1,
   output logic [0:31] out_data2,
   output logic [0:31] out_data3,
   output logic [0:31] out_data4,
   output logic [0:1]  out_resp1,
   output logic [0:1]  out_resp2,
   output logic [0:1]  out_resp3,
   output logic [0:1]  out_resp4,
   input  logic        c_clk,
   input  logic [0:3]  req1_cmd_in,
   input  logic [0:31] req1_data_in,
   input  logic [0:3]  req2_cmd_in,
   input  logic [0:31] req2_data_in,
   input  logic [0:3]  req3_cmd_in,
   input  logic [0:31] req3_data_in,
   input  logic [0:3]  req4_cmd_in,
   input  logic [0:31] req4_data_in,
   input  logic [1:7]  reset
);

   logic w_rst;

   assign w_rst = |reset;

   calc1_port u_port1 (
      .i_clk  (c_clk),
      .i_rst  (w_rst),
      .i_cmd  (req1_cmd_in),
      .i_data (req1_data_in),
      .o_data (out_data1),
      .o_resp (out_resp1)
   );

   calc1_port u_port2 (
      .i_clk  (c_clk),
      .i_rst  (w_rst),
      .i_cmd  (req2_cmd_in),
      .i_data (req2_data_in),
      .o_data (out_data2),
      .o_resp (out_resp2)
   );

   calc1_port u_port3 (
      .i_clk  (c_clk),
      .i_rst  (w_rst),
      .i_cmd  (req3_cmd_in),
      .i_data (req3_data_in),
      .o_data (out_data3),
      .o_resp (out_resp3)
   );

   calc1_port u_port4 (
      .i_clk  (c_clk),
      .i_rst  (w_rst),
      .i_cmd  (req4_cmd_in),
      .i_data (req4_data_in),
      .o_data (out_data4),
      .o_resp (out_resp4)
   );

endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_calc1;

   logic        clk = 1'b0;
   logic [6:0]  rst;
   logic [3:0]  cmd [4];
   logic [31:0] din [4];
   logic [31:0] od  [4];
   logic [1:0]  rs  [4];

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [33:0] Err  = {2'd2, 32'd0};
   localparam logic [33:0] None = 34'd0;

   always #5 clk = ~clk;

   calc1 dut (
      .out_data1    (od[0]),
      .out_data2    (od[1]),
      .out_data3    (od[2]),
      .out_data4    (od[3]),
      .out_resp1    (rs[0]),
      .out_resp2    (rs[1]),
      .out_resp3    (rs[2]),
      .out_resp4    (rs[3]),
      .c_clk        (clk),
      .req1_cmd_in  (cmd[0]),
      .req1_data_in (din[0]),
      .req2_cmd_in  (cmd[1]),
      .req2_data_in (din[1]),
      .req3_cmd_in  (cmd[2]),
      .req3_data_in (din[2]),
      .req4_cmd_in  (cmd[3]),
      .req4_data_in (din[3]),
      .reset        (rst)
   );

   function automatic logic [33:0] ok(input logic [31:0] v);
      return {2'd1, v};
   endfunction

   // Reference: response/data computed from the command rules directly.
   function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] s;
      case (c)
         4'd0: return None;
         4'd1: begin
            s = {32'd0, a} + {32'd0, b};
            if (s > 64'h0000_0000_FFFF_FFFF) return Err;
            return ok(s[31:0]);
         end
         4'd2: begin
            if (b > a) return Err;
            return ok(a - b);
         end
         4'd5: return ok(a << (b % 32));
         4'd6: return ok(a >> (b % 32));
         default: return Err;
      endcase
   endfunction

   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got resp=%0d data=%h, expected resp=%0d data=%h",
                  tag, got[33:32], got[31:0], exp[33:32], exp[31:0]);
      else
         n_pass++;
   endtask

   // Issue one command on port p; called just after a rising edge.
   task automatic op(input int p, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [33:0] exp, input string tag);
      cmd[p] = c;
      din[p] = a;
      @(posedge clk); #1;
      check({tag, "/k0"}, {rs[p], od[p]}, None);
      din[p] = b;
      cmd[p] = (c != 4'd0) ? 4'($urandom) : 4'd0;
      @(posedge clk); #1;
      check(tag, {rs[p], od[p]}, exp);
      cmd[p] = 4'd0;
      din[p] = $urandom;
   endtask

   initial begin
      logic [3:0]  rc;
      logic [31:0] ra, rb;
      logic [3:0]  tbl [8];
      logic [31:0] one;
      int          p;
      tbl = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5};
      one = 32'd1;

      rst = 7'h7F;
      for (int i = 0; i < 4; i++) begin
         cmd[i] = 4'd0;
         din[i] = $urandom;
      end
      cmd[1] = 4'd5;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         check($sformatf("reset_p%0d", i), {rs[i], od[i]}, None);
      cmd[1] = 4'd0;
      rst = 7'h00;

      op(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, ok(32'h2000_0000), "add_first");
      @(posedge clk); #1;
      check("add_first_after", {rs[0], od[0]}, None);
      op(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, Err, "add_ovf");
      op(1, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, ok(32'h3FFF_FFFE), "add_big");
      op(1, 4'd2, 32'd1, 32'd15, Err, "sub_under");
      op(2, 4'd2, 32'd15, 32'd1, ok(32'd14), "sub_ok");
      op(2, 4'd2, 32'd77, 32'd77, ok(32'd0), "sub_eq");
      op(3, 4'd3, 32'd9, 32'd9, Err, "cmd3");
      op(3, 4'd4, 32'd9, 32'd9, Err, "cmd4");
      op(0, 4'd0, 32'd9, 32'd9, None, "cmd0");
      op(0, 4'hF, 32'd1, 32'd1, Err, "cmdF");
      for (int i = 0; i <= 30; i++)
         op(i % 4, 4'd5, one << i, 32'd1, ok(one << (i + 1)), $sformatf("shl%0d", i));
      op(1, 4'd6, 32'h8000_0000, 32'd31, ok(32'd1), "shr31");
      op(2, 4'd5, 32'h0000_0003, 32'hFFFF_FFE1, ok(32'd6), "shl_hibits");
      for (int i = 0; i < 32; i++)
         op(3, 4'd1, one << i, 32'd0, ok(one << i), $sformatf("walk%0d", i));

      // All four ports at once, distinct commands.
      cmd = '{4'd1, 4'd2, 4'd5, 4'd6};
      din = '{32'd100, 32'd50, 32'd3, 32'h0000_00F0};
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check($sformatf("par_k0_p%0d", i), {rs[i], od[i]}, None);
      din = '{32'd23, 32'd8, 32'd4, 32'd4};
      cmd = '{4'd3, 4'd1, 4'd0, 4'd7};
      @(posedge clk); #1;
      check("par_add", {rs[0], od[0]}, ok(32'd123));
      check("par_sub", {rs[1], od[1]}, ok(32'd42));
      check("par_shl", {rs[2], od[2]}, ok(32'd48));
      check("par_shr", {rs[3], od[3]}, ok(32'h0000_000F));
      cmd = '{4'd0, 4'd0, 4'd0, 4'd0};
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check($sformatf("par_end_p%0d", i), {rs[i], od[i]}, None);

      // Reset landing on the OP2 edge aborts every port.
      cmd = '{4'd1, 4'd2, 4'd5, 4'd6};
      din = '{32'd5, 32'd9, 32'd1, 32'd8};
      @(posedge clk); #1;
      cmd = '{4'd0, 4'd0, 4'd0, 4'd0};
      din = '{32'd7, 32'd1, 32'd2, 32'd1};
      rst = 7'b0010000;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check($sformatf("abort_p%0d", i), {rs[i], od[i]}, None);
      rst = 7'h00;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check($sformatf("abort_after_p%0d", i), {rs[i], od[i]}, None);
      rst = 7'b1000000;
      @(posedge clk); #1;
      rst = 7'h00;
      op(0, 4'd1, 32'd2, 32'd3, ok(32'd5), "post_rst");

      // Randomized back-to-back traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         p  = $urandom_range(0, 3);
         rc = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 7)] : 4'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
         op(p, rc, ra, rb, model(rc, ra, rb), $sformatf("rand%0d_c%0d", n, rc));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
